instruction_fetch_unit: RTL and testbench

IF stage of the 5-stage RV32I pipeline, directly upstream of the decode stage.
- Owns the PC.
- Runs a READ/BUSYWAIT handshake with instruction memory (or I-cache).
- Absorbs stalls from the hazard unit and the data-memory busywait.
- Applies branch/jump redirects from EX.
- Drives the IF/ID pipeline register whose outputs (INSTRUCTION, PC_DIRECT, PC_PLUS_4) feed register-file addressing, the control unit and the immediate extender.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/if_id_pipe_reg.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 135 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32I pipeline front end.
// Fetch-state encoding and the IF/ID register layout live here.
package cpu_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: one-cycle latency, holds its contents when neither load nor bubble.
// Bubble wins over load so a squash can never be overridden by a concurrent fetch.
module if_id_pipe_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= '{instr: NOP_INSTR, pc: '0, pc_plus_4: '0, valid: 1'b0};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, runs the READ/BUSYWAIT handshake with instruction memory and feeds IF/ID.
// One instruction per cycle at zero wait; stalls park a returned word in HOLD, redirects drain any in-flight read.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  input  logic        MEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION_OUT,
  output logic [31:0] PC_DIRECT_OUT,
  output logic [31:0] PC_PLUS_4_OUT,
  output logic        VALID_OUT,
  output logic        FETCH_BUSY
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  fetch_buf;
  logic [31:0]  drain_addr;

  logic         adv;
  logic         redir;
  logic [31:0]  target;
  logic [31:0]  pc_plus_4;

  logic         ifid_load;
  logic         ifid_bubble;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  assign adv       = ~STALL & ~MEM_BUSYWAIT;
  assign redir     = BRANCH_TAKEN & ~MEM_BUSYWAIT;
  assign target    = BRANCH_TARGET & ~32'd3;
  assign pc_plus_4 = pc + 32'd4;

  // The request is masked while RESET is high so no read escapes the reset cycle.
  assign IMEM_READ    = ~RESET & (state != HOLD);
  assign IMEM_ADDRESS = (state == DRAIN) ? drain_addr : pc;
  assign FETCH_BUSY   = ((state == FETCH) || (state == DRAIN)) & IMEM_BUSYWAIT;

  always_comb begin
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_d      = '{instr:     (state == HOLD) ? fetch_buf : IMEM_READDATA,
                    pc:        pc,
                    pc_plus_4: pc_plus_4,
                    valid:     1'b1};
    case (state)
      FETCH: begin
        if (redir)                      ifid_bubble = 1'b1;
        else if (!IMEM_BUSYWAIT && adv) ifid_load   = 1'b1;
        else if (IMEM_BUSYWAIT && adv)  ifid_bubble = 1'b1;
      end
      HOLD: begin
        if (redir)    ifid_bubble = 1'b1;
        else if (adv) ifid_load   = 1'b1;
      end
      DRAIN: begin
        if (redir || adv) ifid_bubble = 1'b1;
      end
      default: ifid_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      fetch_buf  <= '0;
      drain_addr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redir) begin
            pc <= target;
            // A read still in flight must finish at its original address before the new PC is used.
            if (IMEM_BUSYWAIT) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end
          end else if (!IMEM_BUSYWAIT) begin
            if (adv) begin
              pc <= pc_plus_4;
            end else begin
              fetch_buf <= IMEM_READDATA;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redir) begin
            pc        <= target;
            fetch_buf <= '0;
            state     <= FETCH;
          end else if (adv) begin
            pc    <= pc_plus_4;
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (redir) pc <= target;
          if (!IMEM_BUSYWAIT) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_pipe_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk    (CLK),
    .reset  (RESET),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign INSTRUCTION_OUT = ifid_q.instr;
  assign PC_DIRECT_OUT   = ifid_q.pc;
  assign PC_PLUS_4_OUT   = ifid_q.pc_plus_4;
  assign VALID_OUT       = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET, BRANCH_TAKEN, STALL, MEM_BUSYWAIT, IMEM_BUSYWAIT;
  logic [31:0] BRANCH_TARGET, IMEM_READDATA;
  logic        IMEM_READ, VALID_OUT, FETCH_BUSY;
  logic [31:0] IMEM_ADDRESS, INSTRUCTION_OUT, PC_DIRECT_OUT, PC_PLUS_4_OUT;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC, an optional parked word, and an optional squashed in-flight read.
  logic [31:0] m_pc;
  logic [31:0] held_q[$];
  logic [31:0] squash_q[$];
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;

  instruction_fetch_unit dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .STALL           (STALL),
    .MEM_BUSYWAIT    (MEM_BUSYWAIT),
    .IMEM_READ       (IMEM_READ),
    .IMEM_ADDRESS    (IMEM_ADDRESS),
    .IMEM_READDATA   (IMEM_READDATA),
    .IMEM_BUSYWAIT   (IMEM_BUSYWAIT),
    .INSTRUCTION_OUT (INSTRUCTION_OUT),
    .PC_DIRECT_OUT   (PC_DIRECT_OUT),
    .PC_PLUS_4_OUT   (PC_PLUS_4_OUT),
    .VALID_OUT       (VALID_OUT),
    .FETCH_BUSY      (FETCH_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_addr();
    return (squash_q.size() != 0) ? squash_q[0] : m_pc;
  endfunction

  task automatic bubble();
    e_instr = NOP;
    e_valid = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] w);
    e_instr = w;
    e_pc    = m_pc;
    e_pc4   = m_pc + 32'd4;
    e_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
  endtask

  // One clock: drive at negedge, check request side, advance model, check IF/ID after the edge.
  task automatic cyc(input bit rst, input bit st, input bit mb, input bit bt,
                     input logic [31:0] tgt, input bit bw);
    bit          adv, redir, rd_req;
    logic [31:0] rd;
    @(negedge CLK);
    rd_req        = (held_q.size() == 0);
    rd            = mem_word(m_addr());
    RESET         = rst;
    STALL         = st;
    MEM_BUSYWAIT  = mb;
    BRANCH_TAKEN  = bt;
    BRANCH_TARGET = tgt;
    IMEM_BUSYWAIT = rd_req ? bw : 1'b0;
    IMEM_READDATA = rd;
    #1;
    if (rst) begin
      chk("read_in_reset", {31'd0, IMEM_READ}, 32'd0);
    end else begin
      chk("imem_read", {31'd0, IMEM_READ}, {31'd0, rd_req});
      if (rd_req) chk("imem_addr", IMEM_ADDRESS, m_addr());
      chk("fetch_busy", {31'd0, FETCH_BUSY}, {31'd0, rd_req & IMEM_BUSYWAIT});
    end

    adv   = !st && !mb;
    redir = bt && !mb;
    if (rst) begin
      m_pc = 32'h0;
      held_q.delete();
      squash_q.delete();
      bubble();
      e_pc  = 32'h0;
      e_pc4 = 32'h0;
    end else if (squash_q.size() != 0) begin
      if (redir) m_pc = {tgt[31:2], 2'b00};
      if (redir || adv) bubble();
      if (!IMEM_BUSYWAIT) squash_q.delete();
    end else if (held_q.size() != 0) begin
      if (redir) begin
        held_q.delete();
        m_pc = {tgt[31:2], 2'b00};
        bubble();
      end else if (adv) begin
        deliver(held_q.pop_front());
      end
    end else begin
      if (redir) begin
        if (IMEM_BUSYWAIT) squash_q.push_back(m_pc);
        m_pc = {tgt[31:2], 2'b00};
        bubble();
      end else if (!IMEM_BUSYWAIT) begin
        if (adv) deliver(rd);
        else held_q.push_back(rd);
      end else if (adv) begin
        bubble();
      end
    end

    @(posedge CLK);
    #1;
    chk("valid", {31'd0, VALID_OUT}, {31'd0, e_valid});
    chk("instr", INSTRUCTION_OUT, e_instr);
    if (e_valid || rst) begin
      chk("pc_direct", PC_DIRECT_OUT, e_pc);
      chk("pc_plus_4", PC_PLUS_4_OUT, e_pc4);
    end
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; MEM_BUSYWAIT = 1'b0; BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = '0; IMEM_BUSYWAIT = 1'b0; IMEM_READDATA = '0;
    m_pc = '0; e_instr = NOP; e_pc = '0; e_pc4 = '0; e_valid = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_instr", INSTRUCTION_OUT, NOP);
    chk("rst_pc", PC_DIRECT_OUT, 32'h0);
    chk("rst_valid", {31'd0, VALID_OUT}, 32'd0);

    // Zero-wait streaming
    cyc(0, 0, 0, 0, 0, 0);
    chk("first_pc", PC_DIRECT_OUT, 32'h0);
    chk("first_word", INSTRUCTION_OUT, mem_word(32'h0));
    cyc(0, 0, 0, 0, 0, 0);
    chk("second_pc", PC_DIRECT_OUT, 32'h4);

    // Three wait cycles on address 8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("wait_addr8", IMEM_ADDRESS, 32'h8);
      chk("wait_bubble", {31'd0, VALID_OUT}, 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("pc8", PC_DIRECT_OUT, 32'h8);
    chk("pc8_plus4", PC_PLUS_4_OUT, 32'hC);
    chk("word8", INSTRUCTION_OUT, mem_word(32'h8));

    // Stall while word@16 returns
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("hold_read", {31'd0, IMEM_READ}, 32'd0);
    chk("hold_pc", PC_DIRECT_OUT, 32'hC);
    cyc(0, 1, 0, 0, 0, 0);
    chk("hold_pc2", PC_DIRECT_OUT, 32'hC);
    cyc(0, 0, 0, 0, 0, 0);
    chk("release_pc", PC_DIRECT_OUT, 32'h10);
    chk("release_word", INSTRUCTION_OUT, mem_word(32'h10));
    chk("next_addr20", IMEM_ADDRESS, 32'h14);

    // Redirect while fetch at 24 is pending
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0000_0101, 1);
    chk("drain_addr", IMEM_ADDRESS, 32'h18);
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_addr2", IMEM_ADDRESS, 32'h18);
    cyc(0, 0, 0, 0, 0, 0);
    chk("after_drain_addr", IMEM_ADDRESS, 32'h100);
    chk("after_drain_valid", {31'd0, VALID_OUT}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("target_pc", PC_DIRECT_OUT, 32'h100);

    // Redirect + stall in HOLD
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'h0000_0200, 0);
    chk("hold_redir_valid", {31'd0, VALID_OUT}, 32'd0);
    chk("hold_redir_addr", IMEM_ADDRESS, 32'h200);

    // Data-memory busywait freezes the stage and masks the redirect
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h0000_0300, 1);
    chk("frozen_pc", PC_DIRECT_OUT, 32'h200);
    chk("frozen_addr", IMEM_ADDRESS, 32'h204);
    cyc(0, 0, 0, 0, 0, 0);
    chk("no_redir_pc", PC_DIRECT_OUT, 32'h204);

    // PC wrap at the top of the address space
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wrap_pc", PC_DIRECT_OUT, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS_4_OUT, 32'h0);
    chk("wrap_addr", IMEM_ADDRESS, 32'h0);

    // Reset in the middle of a drain
    cyc(0, 0, 0, 1, 32'h0000_0040, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("rst_drain_read", {31'd0, IMEM_READ}, 32'd0);
    chk("rst_drain_valid", {31'd0, VALID_OUT}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_pc", PC_DIRECT_OUT, 32'h0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0,
          tgt,
          $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
